// File: rtl/vm_pkg.sv
// Shared vending-machine constants: denomination table, index names, FSM states
// and the note-value decoder also used by the order FSM.
package vm_pkg;
  localparam int NUM_DEN = 12;
  localparam int K_W     = 4;
  localparam int AMT_W   = 16;

  localparam logic [AMT_W-1:0] DEN [NUM_DEN] = '{
    16'd10000, 16'd5000, 16'd2000, 16'd1000, 16'd500, 16'd200,
    16'd100,   16'd50,   16'd25,   16'd10,   16'd5,   16'd1
  };

  localparam logic [K_W-1:0] IDX_10000 = 4'd0;
  localparam logic [K_W-1:0] IDX_5000  = 4'd1;
  localparam logic [K_W-1:0] IDX_2000  = 4'd2;
  localparam logic [K_W-1:0] IDX_1000  = 4'd3;
  localparam logic [K_W-1:0] IDX_500   = 4'd4;
  localparam logic [K_W-1:0] IDX_200   = 4'd5;
  localparam logic [K_W-1:0] IDX_100   = 4'd6;
  localparam logic [K_W-1:0] IDX_50    = 4'd7;
  localparam logic [K_W-1:0] IDX_25    = 4'd8;
  localparam logic [K_W-1:0] IDX_10    = 4'd9;
  localparam logic [K_W-1:0] IDX_5     = 4'd10;
  localparam logic [K_W-1:0] IDX_1     = 4'd11;
  localparam logic [K_W-1:0] K_ONE     = 4'd1;

  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, DONE} state_t;

  typedef struct packed {
    logic           valid;
    logic [K_W-1:0] idx;
  } note_dec_t;

  function automatic note_dec_t note_decode(input logic [AMT_W-1:0] note);
    note_dec_t d;
    d = '0;
    for (int i = 0; i < NUM_DEN; i++)
      if (note == DEN[i]) begin
        d.valid = 1'b1;
        d.idx   = K_W'(i);
      end
    return d;
  endfunction
endpackage

// File: rtl/vm_change_plan_step.sv
// One greedy planning step: how many notes of DEN[k] to take given the
// remaining amount and the stock, and what remains afterwards.
module vm_change_plan_step
  import vm_pkg::*;
#(
  parameter int CASH_WIDTH = 10
) (
  input  logic [AMT_W-1:0]      rem,
  input  logic [K_W-1:0]        k,
  input  logic [CASH_WIDTH-1:0] cnt,
  output logic [CASH_WIDTH-1:0] plan_k,
  output logic [AMT_W-1:0]      rem_next
);
  logic [AMT_W-1:0] quot;
  logic [AMT_W-1:0] den_k;

  // Constant divisors per index keep each divider a fixed-constant one.
  always_comb begin
    quot  = '0;
    den_k = '0;
    for (int i = 0; i < NUM_DEN; i++)
      if (k == K_W'(i)) begin
        quot  = rem / DEN[i];
        den_k = DEN[i];
      end
    if (quot > AMT_W'(cnt)) plan_k = cnt;
    else                    plan_k = quot[CASH_WIDTH-1:0];
    rem_next = rem - AMT_W'(AMT_W'(plan_k) * den_k);
  end
endmodule

// File: rtl/vm_change_scheduler.sv
// Change-dispensing controller: greedy plan over 12 denominations against the
// live inventory, then one note per clock, or a no-change report.
module vm_change_scheduler
  import vm_pkg::*;
#(
  parameter int CASH_WIDTH = 10,
  parameter int CASH_100   = 100,
  parameter int CASH_50    = 100,
  parameter int CASH_20    = 100,
  parameter int CASH_10    = 100,
  parameter int CASH_5     = 100,
  parameter int CASH_2     = 100,
  parameter int CASH_1     = 100,
  parameter int CASH_05    = 100,
  parameter int CASH_025   = 100,
  parameter int CASH_01    = 100,
  parameter int CASH_005   = 100,
  parameter int CASH_001   = 100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_deposit,
  input  logic [AMT_W-1:0] i_note,
  output logic             o_busy,
  output logic [AMT_W-1:0] o_change,
  output logic             o_strobe_ch,
  output logic             o_done,
  output logic             o_no_change,
  output logic             o_dep_reject
);
  localparam logic [CASH_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CASH_WIDTH-1:0] ONE     = 1;
  localparam logic [NUM_DEN-1:0][CASH_WIDTH-1:0] CNT_INIT = {
    CASH_WIDTH'(CASH_001), CASH_WIDTH'(CASH_005), CASH_WIDTH'(CASH_01),
    CASH_WIDTH'(CASH_025), CASH_WIDTH'(CASH_05),  CASH_WIDTH'(CASH_1),
    CASH_WIDTH'(CASH_2),   CASH_WIDTH'(CASH_5),   CASH_WIDTH'(CASH_10),
    CASH_WIDTH'(CASH_20),  CASH_WIDTH'(CASH_50),  CASH_WIDTH'(CASH_100)
  };

  state_t                             state, state_nxt;
  logic [AMT_W-1:0]                   rem;
  logic [K_W-1:0]                     k;
  logic                               fail;
  logic [NUM_DEN-1:0][CASH_WIDTH-1:0] cnt, plan;
  logic                               dep_reject;

  logic [CASH_WIDTH-1:0] step_plan;
  logic [AMT_W-1:0]      step_rem;
  logic                  pick_vld;
  logic [K_W-1:0]        pick;
  note_dec_t             dec;
  logic                  dep_ok, dep_bad;

  vm_change_plan_step #(.CASH_WIDTH(CASH_WIDTH)) u_step (
    .rem     (rem),
    .k       (k),
    .cnt     (cnt[k]),
    .plan_k  (step_plan),
    .rem_next(step_rem)
  );

  // Lowest index with notes left = largest denomination first.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_DEN - 1; i >= 0; i--)
      if (plan[i] != '0) begin
        pick_vld = 1'b1;
        pick     = K_W'(i);
      end
  end

  assign dec     = note_decode(i_note);
  assign dep_ok  = i_deposit && state == IDLE && !i_start && dec.valid &&
                   cnt[dec.idx] != CNT_MAX;
  assign dep_bad = i_deposit && !dep_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_start) state_nxt = CHECK;
      CHECK:    if (k == IDX_1) state_nxt = (step_rem == '0) ? DISPENSE : DONE;
      DISPENSE: if (!pick_vld) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = state != IDLE;
    o_strobe_ch  = state == DISPENSE && pick_vld;
    o_change     = o_strobe_ch ? DEN[pick] : '0;
    o_done       = state == DONE;
    o_no_change  = state == DONE && fail;
    o_dep_reject = dep_reject;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem        <= '0;
      k          <= '0;
      fail       <= 1'b0;
      plan       <= '0;
      cnt        <= CNT_INIT;
      dep_reject <= 1'b0;
    end else begin
      dep_reject <= dep_bad;
      case (state)
        IDLE: begin
          if (i_start) begin
            rem  <= i_amount;
            k    <= '0;
            fail <= 1'b0;
            plan <= '0;
          end else if (dep_ok) begin
            cnt[dec.idx] <= cnt[dec.idx] + ONE;
          end
        end
        CHECK: begin
          plan[k] <= step_plan;
          rem     <= step_rem;
          if (k != IDX_1)          k    <= k + K_ONE;
          else if (step_rem != '0) fail <= 1'b1;
        end
        DISPENSE: begin
          if (pick_vld) begin
            plan[pick] <= plan[pick] - ONE;
            cnt[pick]  <= cnt[pick] - ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vm_change_scheduler.sv
// Randomized bench for vm_change_scheduler: a transaction-level greedy model
// predicts every output per cycle; literal expectations pin key cycles.
module tb_vm_change_scheduler;
  localparam int MAXS    = 40000;
  localparam int RUN_END = 30000;
  localparam int CMAX    = 1023;
  localparam int F_BUSY = 0, F_STB = 1, F_CHG = 2, F_DONE = 3, F_NC = 4, F_REJ = 5;

  logic        clk = 1'b0;
  logic        rst, start_r, deposit;
  logic [15:0] amount, note;
  logic        busy, strobe, done, no_change, dep_reject;
  logic [15:0] change;

  vm_change_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_r), .i_amount(amount),
    .i_deposit(deposit), .i_note(note), .o_busy(busy), .o_change(change),
    .o_strobe_ch(strobe), .o_done(done), .o_no_change(no_change),
    .o_dep_reject(dep_reject)
  );

  always #5 clk = ~clk;

  int den [12] = '{10000, 5000, 2000, 1000, 500, 200, 100, 50, 25, 10, 5, 1};
  int inv [12];
  bit exp_busy [MAXS];
  bit exp_stb  [MAXS];
  int exp_chg  [MAXS];
  bit exp_done [MAXS];
  bit exp_nc   [MAXS];
  bit exp_rej  [MAXS];
  int ecount    = 0;
  int free_edge = 0;
  int total = 0, bad = 0;
  bit tmo_flag = 0;

  typedef struct { int slot; int field; int val; } lit_t;
  lit_t lits [$];

  function automatic int den_index(input int v);
    for (int i = 0; i < 12; i++) if (den[i] == v) return i;
    return -1;
  endfunction

  // Greedy plan against the model inventory, then lay out the output timeline.
  task automatic schedule(input int e, input int amt);
    int take [12];
    int r, n;
    r = amt;
    for (int i = 0; i < 12; i++) begin
      take[i] = r / den[i];
      if (take[i] > inv[i]) take[i] = inv[i];
      r -= take[i] * den[i];
    end
    if (r != 0) begin
      for (int s = e; s <= e + 12 && s < MAXS; s++) exp_busy[s] = 1;
      if (e + 12 < MAXS) begin exp_done[e+12] = 1; exp_nc[e+12] = 1; end
      free_edge = e + 14;
    end else begin
      n = 0;
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < take[i]; j++) begin
          if (e + 12 + n < MAXS) begin exp_stb[e+12+n] = 1; exp_chg[e+12+n] = den[i]; end
          n++;
        end
        inv[i] -= take[i];
      end
      for (int s = e; s <= e + 13 + n && s < MAXS; s++) exp_busy[s] = 1;
      if (e + 13 + n < MAXS) exp_done[e+13+n] = 1;
      free_edge = e + 15 + n;
    end
  endtask

  always @(posedge clk) begin : model
    int e, di;
    e = ecount;
    if (rst) begin
      for (int i = 0; i < 12; i++) inv[i] = 100;
      for (int s = e; s < MAXS; s++) begin
        exp_busy[s] = 0; exp_stb[s] = 0; exp_chg[s] = 0;
        exp_done[s] = 0; exp_nc[s] = 0; exp_rej[s] = 0;
      end
      free_edge = e + 1;
    end else begin
      if (deposit) begin
        di = den_index(int'(note));
        if (e >= free_edge && !start_r && di >= 0 && inv[di] < CMAX) inv[di]++;
        else if (e < MAXS) exp_rej[e] = 1;
      end
      if (start_r && e >= free_edge) schedule(e, int'(amount));
    end
    ecount = e + 1;
  end

  task automatic cmp(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s slot=%0d got=%0d want=%0d", nm, ecount - 1, act, want);
    end
  endtask

  function automatic int field_val(input int f);
    case (f)
      F_BUSY: return int'(busy);
      F_STB:  return int'(strobe);
      F_CHG:  return int'(change);
      F_DONE: return int'(done);
      F_NC:   return int'(no_change);
      default: return int'(dep_reject);
    endcase
  endfunction

  int  lit_ptr  = 0;
  bit  tmo_seen = 0;
  always @(negedge clk) begin : compare
    int s;
    if (ecount > 0 && ecount <= MAXS) begin
      s = ecount - 1;
      cmp("busy",      int'(busy),       int'(exp_busy[s]));
      cmp("strobe",    int'(strobe),     int'(exp_stb[s]));
      cmp("change",    int'(change),     exp_chg[s]);
      cmp("done",      int'(done),       int'(exp_done[s]));
      cmp("no_change", int'(no_change),  int'(exp_nc[s]));
      cmp("dep_rej",   int'(dep_reject), int'(exp_rej[s]));
      while (lit_ptr < lits.size() && lits[lit_ptr].slot <= s) begin
        if (lits[lit_ptr].slot == s)
          cmp($sformatf("literal_f%0d", lits[lit_ptr].field),
              field_val(lits[lit_ptr].field), lits[lit_ptr].val);
        lit_ptr++;
      end
    end
    if (tmo_flag && !tmo_seen) begin
      tmo_seen = 1;
      cmp("wait_bound", 1, 0);
    end
  end

  task automatic lit(input int slot, input int f, input int v);
    lit_t x;
    x.slot = slot; x.field = f; x.val = v;
    lits.push_back(x);
  endtask

  task automatic lit_all_zero(input int slot);
    for (int f = 0; f < 6; f++) lit(slot, f, 0);
  endtask

  task automatic wait_free();
    int n = 0;
    while (ecount < free_edge) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin tmo_flag = 1; break; end
    end
  endtask

  task automatic start_req(input int a, output int e);
    wait_free();
    e = ecount; start_r = 1; amount = 16'(a);
    @(negedge clk);
    start_r = 0;
  endtask

  task automatic dep_req(input int v, input int rej_exp);
    int d;
    d = ecount; deposit = 1; note = 16'(v);
    lit(d, F_REJ, rej_exp);
    @(negedge clk);
    deposit = 0;
  endtask

  function automatic logic [15:0] rnd_amount();
    case ($urandom_range(0, 4))
      0: return 16'($urandom_range(0, 40));
      1: return 16'($urandom_range(0, 500));
      2: return 16'(den[$urandom_range(0, 11)] * $urandom_range(1, 3));
      3: return 16'($urandom_range(0, 65535));
      default: return 16'($urandom_range(0, 5000));
    endcase
  endfunction

  initial begin : drive
    int e, e2;
    rst = 1; start_r = 0; deposit = 0; amount = '0; note = '0;
    lit_all_zero(0);
    lit_all_zero(1);
    repeat (3) @(negedge clk);
    rst = 0;

    start_req(400, e);
    lit(e+12, F_STB, 1); lit(e+12, F_CHG, 200);
    lit(e+13, F_STB, 1); lit(e+13, F_CHG, 200);
    lit(e+14, F_STB, 0); lit(e+14, F_BUSY, 1);
    lit(e+15, F_DONE, 1); lit(e+15, F_NC, 0);
    lit(e+16, F_BUSY, 0);

    start_req(0, e);
    lit(e+11, F_BUSY, 1); lit(e+12, F_STB, 0);
    lit(e+13, F_DONE, 1); lit(e+13, F_NC, 0);
    lit(e+14, F_BUSY, 0);

    wait_free();
    dep_req(500, 0);
    dep_req(300, 1);
    start_req(50, e);
    lit(ecount, F_BUSY, 1);
    dep_req(100, 1);
    wait_free();
    e = ecount; start_r = 1; amount = 16'd10; deposit = 1; note = 16'd10;
    lit(e, F_REJ, 1); lit(e+12, F_STB, 1); lit(e+12, F_CHG, 10);
    @(negedge clk);
    start_r = 0; deposit = 0;

    for (int i = 0; i < 25; i++) start_req(4, e);
    start_req(3, e);
    lit(e+11, F_BUSY, 1);
    lit(e+12, F_DONE, 1); lit(e+12, F_NC, 1); lit(e+12, F_STB, 0);
    lit(e+13, F_BUSY, 0);

    start_req(400, e);
    while (ecount - 1 < e + 13) @(negedge clk);
    rst = 1;
    lit_all_zero(e+14);
    @(negedge clk);
    rst = 0;
    start_req(400, e2);
    lit(e2+12, F_CHG, 200); lit(e2+13, F_CHG, 200);
    lit(e2+15, F_DONE, 1); lit(e2+15, F_NC, 0);

    while (ecount < RUN_END) begin
      rst     = ($urandom_range(0, 2999) == 0);
      start_r = ($urandom_range(0, 15) == 0);
      amount  = rnd_amount();
      deposit = ($urandom_range(0, 3) == 0);
      note    = ($urandom_range(0, 3) != 0) ? 16'(den[$urandom_range(0, 11)])
                                            : 16'($urandom_range(0, 65535));
      @(negedge clk);
    end
    rst = 0; start_r = 0; deposit = 0;
    wait_free();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
